button_conditioner: RTL
=======================

// Module: button_conditioner
// PURPOSE
//  Front end for the stopwatch: takes raw active-low push buttons, synchronises, debounces and
//  converts them into clean levels and single-cycle press/release pulses. Its outputs drive the
//  stopwatch start/pause and reset inputs, so one physical press produces exactly one action.
// PARAMETERS
//  NUM_BTN          4        number of buttons handled (one debounce channel each)
//  DEBOUNCE_CYCLES  1000000  stable-sample count to accept a change (20 ms @ 50 MHz); must be >= 1
//  LONG_CYCLES      50000000 held-press duration for long_o (1 s @ 50 MHz); used only with LONG_PRESS_EN
// PORTS
//  clock      in   1        system clock, rising edge
//  reset_n    in   1        asynchronous reset, active low
//  button_i   in   NUM_BTN  raw buttons, active low (1 = released), asynchronous to clock
//  level_o    out  NUM_BTN  debounced state, active high (1 = pressed)
//  press_o    out  NUM_BTN  1-cycle pulse on accepted press
//  release_o  out  NUM_BTN  1-cycle pulse on accepted release
//  long_o     out  NUM_BTN  1-cycle pulse when a press has been held LONG_CYCLES cycles
// BEHAVIOUR
//  - One clock; reset is asynchronous, active-low (reset_n). All state is clocked on rising clock.
//  - Reset values: sync flops = 1 (released); level_o, press_o, release_o, long_o = 0; counters = 0.
//  - Per button: 2-flop synchroniser on button_i, inverted to active-high sample s.
//  - Debounce counter cnt (width $clog2(DEBOUNCE_CYCLES+1)):
//      s == level_o            -> cnt <= 0
//      s != level_o, cnt < D-1 -> cnt <= cnt+1
//      s != level_o, cnt == D-1-> level_o <= s, cnt <= 0, press_o/release_o asserted same edge
//  - Latency: level_o changes on the (DEBOUNCE_CYCLES+2)th rising edge from the edge that first
//    samples the new raw value; press_o/release_o are high for exactly that one cycle.
//  - Any reversion of s before acceptance clears cnt: glitches shorter than D cycles are invisible.
//  - press_o and release_o are mutually exclusive per button; channels fully independent,
//    simultaneous events on different buttons all reported in the same cycle.
//  - Reset asserted mid-count or mid-press: everything returns to reset values; a button still
//    held when reset_n deasserts is debounced afresh and yields one press_o after D+2 edges.
//  - No wrap-around: cnt saturates by construction at D-1.
// CONFIGURATION
//  - Macro LONG_PRESS_EN. Defined: per-button hold counter (width $clog2(LONG_CYCLES+1)) runs
//    while level_o=1, cleared when level_o=0; long_o pulses once on the cycle the counter reaches
//    LONG_CYCLES, then counter holds until release (one long_o per press).
//  - Not defined: no hold counters; long_o tied to 0. Port list identical in both builds.
// STRUCTURE
//  - Shared header stopwatch_defs.vh: button index constants BTN_START=3, BTN_RESET=1,
//    BTN_AUX0=0, BTN_AUX2=2; default timing constants for 50 MHz board.
//  - Sub-module debounce_bit (sync + debounce + edge pulses + optional hold counter for one
//    button); top instantiates NUM_BTN copies in a generate loop.
// TESTING  (bench overrides DEBOUNCE_CYCLES=4, LONG_CYCLES=16, 20 ns clock)
//  1 Reset: reset_n=0 with button_i=4'b1111 -> all outputs 0; hold during clock edges, still 0.
//  2 Clean press: button_i[3] 1->0 held 20 cycles -> level_o[3]=1 and press_o[3] single pulse on
//    6th edge after change; release after 20 cycles -> release_o[3] single pulse 6 edges later.
//  3 Bounce: button_i[1] toggles every 2 cycles for 12 cycles then held 0 -> no pulse during
//    bouncing; exactly one press_o[1] 6 edges after final stable level.
//  4 Glitch: button_i[0] low for 3 cycles then high -> level_o/press_o/release_o[0] stay 0.
//  5 Simultaneous: buttons 3 and 1 pressed same cycle -> press_o=4'b1010 in one cycle.
//  6 Mid-operation reset: reset_n pulsed low while button 3 held and level_o[3]=1 -> outputs 0
//    asynchronously; after release of reset, one press_o[3] 6 edges later; with LONG_PRESS_EN,
//    continued hold gives one long_o[3] 16 cycles after level_o[3] rises, none without macro.

Source files
------------

// File: rtl/button_conditioner_pkg.sv
// Shared constants for the stopwatch button front end: button indices and 50 MHz timing defaults.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package button_conditioner_pkg;

    // Which physical button drives which stopwatch action
    localparam int unsigned BTN_AUX0  = 0;
    localparam int unsigned BTN_RESET = 1;
    localparam int unsigned BTN_AUX2  = 2;
    localparam int unsigned BTN_START = 3;

    // Board defaults for a 50 MHz clock
    localparam int unsigned DEF_NUM_BTN         = 4;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;   // 20 ms
    localparam int unsigned DEF_LONG_CYCLES     = 50000000;  // 1 s

    // Bits needed to hold the values 0..max_count (never less than one bit)
    function automatic int unsigned count_width(input int unsigned max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/button_conditioner_debounce_bit.sv
// One button channel: 2-flop sync, debounce counter, press/release pulses, optional long-press (LONG_PRESS_EN).
// Latency: level/pulse appear DEBOUNCE_CYCLES+2 edges after the first edge that samples a new raw value.
// Backpressure: none; free-running, pulses are single-cycle and never held or queued.
module button_conditioner_debounce_bit
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES
) (
    input  logic clock,
    input  logic reset_n,
    input  logic button_n,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int unsigned      CNT_W    = count_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // A zero-length debounce or hold time has no meaning; refuse to elaborate
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be >= 1");
    end
    if (LONG_CYCLES < 1) begin : g_bad_long
        $error("LONG_CYCLES must be >= 1");
    end

    logic             sync_q1;
    logic             sync_q2;
    logic             sample;
    logic [CNT_W-1:0] cnt;

    // Two-stage synchroniser; resets to the released (high) state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
        end else begin
            sync_q1 <= button_n;
            sync_q2 <= sync_q1;
        end
    end

    assign sample = ~sync_q2;

    // Accept a new level only after it has differed from the current one for DEBOUNCE_CYCLES edges in a row
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt           <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            if (sample == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt           <= '0;
                level         <= sample;
                press_pulse   <= sample;
                release_pulse <= ~sample;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

`ifdef LONG_PRESS_EN
    localparam int unsigned       HOLD_W    = count_width(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    logic [HOLD_W-1:0] hold_cnt;

    // Count held cycles, pulse once on reaching LONG_CYCLES, then park until release
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt   <= '0;
            long_pulse <= 1'b0;
        end else if (!level) begin
            hold_cnt   <= '0;
            long_pulse <= 1'b0;
        end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt   <= hold_cnt + HOLD_ONE;
            long_pulse <= (hold_cnt == HOLD_PRE);
        end else begin
            long_pulse <= 1'b0;
        end
    end
`else
    assign long_pulse = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Stopwatch button front end: NUM_BTN independent sync/debounce channels; LONG_PRESS_EN adds long_o.
// Latency: DEBOUNCE_CYCLES+2 edges from first sampling of a new raw value to level_o/press_o/release_o.
// Backpressure: none; outputs are single-cycle pulses that the consumer must take when they occur.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned NUM_BTN         = DEF_NUM_BTN,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_BTN-1:0] button_i,
    output logic [NUM_BTN-1:0] level_o,
    output logic [NUM_BTN-1:0] press_o,
    output logic [NUM_BTN-1:0] release_o,
    output logic [NUM_BTN-1:0] long_o
);

    // One fully independent channel per button
    for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
        button_conditioner_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES)
        ) u_bit (
            .clock         (clock),
            .reset_n       (reset_n),
            .button_n      (button_i[b]),
            .level         (level_o[b]),
            .press_pulse   (press_o[b]),
            .release_pulse (release_o[b]),
            .long_pulse    (long_o[b])
        );
    end

endmodule
